pipeline_run_ctrl: RTL and testbench

- Run/debug sequencer for the 5-stage MIPS pipeline.
- Generates the single global advance enable `go`. The datapath uses `go` wherever it now uses `halt && stop`: pipeline registers, the PC enable term and the statistics halt input.
- Provides free-run, single-step and PC-breakpoint modes.
- Latches the syscall-0xA termination.
- Conditions the raw board buttons.
- Reports state and a cycles-advanced count to the display mux.

---
 rtl/pipeline_run_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pipeline_run_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_run_ctrl.sv
// Run/debug sequencer for the 5-stage MIPS pipeline.
// Produces the global advance enable `go` and supports free-run, single-step
// and PC-breakpoint modes. It also latches the syscall-0xA termination,
// conditions the raw board buttons, and counts the cycles the pipeline advanced.
module pipeline_run_ctrl #(
  parameter int PC_W     = 12,
  parameter int CNT_W    = 32,
  parameter int DEBOUNCE = 16,
  parameter bit AUTO_RUN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       run_mode,
  input  logic             step_btn,
  input  logic             resume_btn,
  input  logic             bp_enable,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pc,
  input  logic             syscall_halt,
  output logic             go,
  output logic [2:0]       state,
  output logic [1:0]       halt_reason,
  output logic [CNT_W-1:0] adv_count
);

  typedef enum logic [2:0] {
    S_RUN      = 3'd0,
    S_PAUSE    = 3'd1,
    S_STEP     = 3'd2,
    S_BP_HALT  = 3'd3,
    S_SYS_HALT = 3'd4
  } state_t;

  localparam int              DB_W    = $clog2(DEBOUNCE);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);

  // Bit 0 carries the step button, bit 1 the resume button.
  logic [1:0]      raw_btn;
  logic [1:0]      meta_p0;
  logic [1:0]      sync_p1;
  logic [1:0]      clean_lvl;
  logic [1:0]      db_last;
  logic [1:0]      rise;
  logic [DB_W-1:0] db_cnt [2];
  logic            step_p;
  logic            resume_p;

  state_t           state_q;
  state_t           state_nxt;
  logic [1:0]       reason_q;
  logic             bp_skip;
  logic             bp_hit;
  logic             bp_leave;
  logic             mode_ss;
  logic             mode_bp;
  logic [CNT_W-1:0] adv_q;

  // Saturating increment: the count sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Display code for the reason the pipeline is (or is not) stopped.
  function automatic logic [1:0] reason_of(input state_t s);
    case (s)
      S_RUN:              return 2'b00;
      S_PAUSE, S_STEP:    return 2'b01;
      S_BP_HALT:          return 2'b10;
      default:            return 2'b11;
    endcase
  endfunction

  assign raw_btn  = {resume_btn, step_btn};
  assign db_last  = {db_cnt[1] == DB_LAST, db_cnt[0] == DB_LAST};
  // The pulse marks the cycle in which a rising clean level is accepted.
  assign rise     = ~clean_lvl & sync_p1 & db_last;
  assign step_p   = rise[0];
  assign resume_p = rise[1];

  // Stage p0 -> p1: two-flop synchronizer, then the debounce counter that
  // only flips the clean level after DEBOUNCE consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_p0   <= '0;
      sync_p1   <= '0;
      clean_lvl <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      meta_p0 <= raw_btn;
      sync_p1 <= meta_p0;
      for (int i = 0; i < 2; i++) begin
        if (sync_p1[i] == clean_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_last[i]) begin
          clean_lvl[i] <= sync_p1[i];
          db_cnt[i]    <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign mode_ss  = (run_mode == 2'b01);
  assign mode_bp  = (run_mode == 2'b10);
  assign bp_hit   = bp_enable && mode_bp && (pc == bp_addr) && !bp_skip;
  // Combinational so the pipeline freezes in the very cycle a halt condition appears.
  assign go       = ((state_q == S_RUN) || (state_q == S_STEP)) && !syscall_halt && !bp_hit;
  assign bp_leave = (state_q == S_BP_HALT) && !syscall_halt && (resume_p || step_p);

  // Next-state selection; syscall termination has priority over everything else.
  always_comb begin
    state_nxt = state_q;
    if (syscall_halt) begin
      state_nxt = S_SYS_HALT;
    end else begin
      case (state_q)
        S_RUN: begin
          if (bp_hit)       state_nxt = S_BP_HALT;
          else if (mode_ss) state_nxt = S_PAUSE;
        end
        S_STEP: begin
          if (bp_hit) state_nxt = S_BP_HALT;
          else        state_nxt = S_PAUSE;
        end
        S_PAUSE: begin
          if (resume_p && !mode_ss) state_nxt = S_RUN;
          else if (step_p)          state_nxt = S_STEP;
        end
        S_BP_HALT: begin
          if (resume_p)    state_nxt = S_RUN;
          else if (step_p) state_nxt = S_STEP;
        end
        S_SYS_HALT: state_nxt = S_SYS_HALT;
        default:    state_nxt = S_PAUSE;
      endcase
    end
  end

  // FSM register with registered halt reason, breakpoint skip flag and advance count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= AUTO_RUN ? S_RUN : S_PAUSE;
      reason_q <= AUTO_RUN ? 2'b00 : 2'b01;
      bp_skip  <= 1'b0;
      adv_q    <= '0;
    end else begin
      state_q  <= state_nxt;
      reason_q <= reason_of(state_nxt);
      // Leaving the breakpoint must not re-trigger on the PC we are parked on.
      if (bp_leave)            bp_skip <= 1'b1;
      else if (pc != bp_addr)  bp_skip <= 1'b0;
      if (go) adv_q <= sat_inc(adv_q);
    end
  end

  assign state       = state_q;
  assign halt_reason = reason_q;
  assign adv_count   = adv_q;

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Directed bench for pipeline_run_ctrl: reset, free-run, syscall termination,
// single-step, bounce rejection, breakpoint and simultaneous-event scenarios.
module tb_pipeline_run_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  run_mode;
  logic        step_btn;
  logic        resume_btn;
  logic        bp_enable;
  logic [11:0] bp_addr;
  logic [11:0] pc;
  logic        syscall_halt;

  logic        go;
  logic [2:0]  state;
  logic [1:0]  halt_reason;
  logic [31:0] adv_count;

  logic        go_s;
  logic [2:0]  state_s;
  logic [1:0]  halt_s;
  logic [3:0]  adv_s;

  logic        go_b;
  logic [2:0]  state_b;
  logic [1:0]  halt_b;
  logic [31:0] adv_b;

  int vectors;
  int miscompares;

  always #5 clk = ~clk;

  pipeline_run_ctrl #(.PC_W(12), .CNT_W(32), .DEBOUNCE(16), .AUTO_RUN(1'b1)) dut (
    .clk(clk), .rst(rst), .run_mode(run_mode), .step_btn(step_btn),
    .resume_btn(resume_btn), .bp_enable(bp_enable), .bp_addr(bp_addr), .pc(pc),
    .syscall_halt(syscall_halt), .go(go), .state(state), .halt_reason(halt_reason),
    .adv_count(adv_count)
  );

  // Narrow counter copy to reach the saturation boundary quickly.
  pipeline_run_ctrl #(.PC_W(12), .CNT_W(4), .DEBOUNCE(16), .AUTO_RUN(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .run_mode(run_mode), .step_btn(step_btn),
    .resume_btn(resume_btn), .bp_enable(bp_enable), .bp_addr(bp_addr), .pc(pc),
    .syscall_halt(syscall_halt), .go(go_s), .state(state_s), .halt_reason(halt_s),
    .adv_count(adv_s)
  );

  // Copy that comes out of reset paused.
  pipeline_run_ctrl #(.PC_W(12), .CNT_W(32), .DEBOUNCE(16), .AUTO_RUN(1'b0)) dut_paused (
    .clk(clk), .rst(rst), .run_mode(run_mode), .step_btn(step_btn),
    .resume_btn(resume_btn), .bp_enable(bp_enable), .bp_addr(bp_addr), .pc(pc),
    .syscall_halt(syscall_halt), .go(go_b), .state(state_b), .halt_reason(halt_b),
    .adv_count(adv_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: PC advances by 4 (looping 0x020 -> 0x000) when go was high.
  task automatic tick();
    logic g;
    #1;
    g = go;
    @(posedge clk);
    @(negedge clk);
    if (g === 1'b1) pc = (pc == 12'h020) ? 12'h000 : pc + 12'h004;
    #1;
  endtask

  // Clean 20-cycle step press from PAUSE: exactly one go cycle, 18 cycles after the raw edge.
  task automatic press_step(input string tag);
    step_btn = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 20) step_btn = 1'b0;
      check({tag, "_go"}, 32'(go), 32'(k == 18));
      if (k == 18) check({tag, "_state_step"}, 32'(state), 32'd2);
      if (k == 19) check({tag, "_state_pause"}, 32'(state), 32'd1);
    end
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst          = 1'b1;
    run_mode     = 2'b00;
    step_btn     = 1'b0;
    resume_btn   = 1'b0;
    bp_enable    = 1'b0;
    bp_addr      = 12'h010;
    pc           = 12'h000;
    syscall_halt = 1'b0;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    pc  = 12'h000;
    #1;

    // Reset defaults
    check("rst_state", 32'(state), 32'd0);
    check("rst_reason", 32'(halt_reason), 32'd0);
    check("rst_count", adv_count, 32'd0);
    check("rst_go", 32'(go), 32'd1);
    check("sat_rst_state", 32'(state_s), 32'd0);
    check("sat_rst_go", 32'(go_s), 32'd1);
    check("paused_rst_state", 32'(state_b), 32'd1);
    check("paused_rst_reason", 32'(halt_b), 32'd1);
    check("paused_rst_go", 32'(go_b), 32'd0);
    check("paused_rst_count", adv_b, 32'd0);

    // Free run
    repeat (10) tick();
    check("run_count10", adv_count, 32'd10);
    check("run_state", 32'(state), 32'd0);
    repeat (8) tick();
    check("run_count18", adv_count, 32'd18);
    check("sat_count", 32'(adv_s), 32'd15);
    check("sat_reason", 32'(halt_s), 32'd0);

    // Syscall termination
    syscall_halt = 1'b1;
    #1;
    check("sys_go_same_cycle", 32'(go), 32'd0);
    tick();
    check("sys_state", 32'(state), 32'd4);
    check("sys_reason", 32'(halt_reason), 32'd3);
    check("sys_count", adv_count, 32'd18);
    syscall_halt = 1'b0;
    step_btn     = 1'b1;
    resume_btn   = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 20) begin
        step_btn   = 1'b0;
        resume_btn = 1'b0;
      end
      check("sys_hold_go", 32'(go), 32'd0);
      check("sys_hold_state", 32'(state), 32'd4);
    end
    check("sys_count_frozen", adv_count, 32'd18);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("sys_rst_state", 32'(state), 32'd0);
    check("sys_rst_count", adv_count, 32'd0);

    // Single-step
    run_mode = 2'b01;
    tick();
    check("ss_state", 32'(state), 32'd1);
    check("ss_reason", 32'(halt_reason), 32'd1);
    check("ss_go", 32'(go), 32'd0);
    check("ss_count_entry", adv_count, 32'd1);
    press_step("ss1");
    press_step("ss2");
    press_step("ss3");
    check("ss_count", adv_count, 32'd4);

    // Bounce rejection
    for (int k = 0; k < 40; k++) begin
      step_btn = ((k / 3) % 2 == 0);
      tick();
      check("bounce_go", 32'(go), 32'd0);
    end
    press_step("bounce");
    check("bounce_count", adv_count, 32'd5);

    // Breakpoint: resume from PAUSE, run 0x000..0x00C, freeze at 0x010
    pc         = 12'h000;
    run_mode   = 2'b10;
    bp_enable  = 1'b1;
    bp_addr    = 12'h010;
    resume_btn = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 20) resume_btn = 1'b0;
      if (k < 18) check("bp_wait_go", 32'(go), 32'd0);
      if (k == 18) check("bp_resume_go", 32'(go), 32'd1);
      if (k == 22) begin
        check("bp_hit_go", 32'(go), 32'd0);
        check("bp_hit_pc", 32'(pc), 32'h010);
        check("bp_hit_state_run", 32'(state), 32'd0);
      end
      if (k == 23) check("bp_reason", 32'(halt_reason), 32'd2);
      if (k >= 23) begin
        check("bp_state", 32'(state), 32'd3);
        check("bp_hold_go", 32'(go), 32'd0);
        check("bp_hold_pc", 32'(pc), 32'h010);
      end
    end
    check("bp_count", adv_count, 32'd9);

    // Resume from the breakpoint: no re-trigger at 0x010, halts again after the loop
    resume_btn = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 20) resume_btn = 1'b0;
      if (k < 18) check("bp2_wait_state", 32'(state), 32'd3);
      if (k == 18) begin
        check("bp2_no_retrigger_state", 32'(state), 32'd0);
        check("bp2_no_retrigger_go", 32'(go), 32'd1);
      end
      if (k == 19) begin
        check("bp2_pc_moved", 32'(pc), 32'h014);
        check("bp2_go", 32'(go), 32'd1);
      end
      if (k == 27) begin
        check("bp2_rehit_go", 32'(go), 32'd0);
        check("bp2_rehit_pc", 32'(pc), 32'h010);
      end
      if (k >= 28) begin
        check("bp2_state", 32'(state), 32'd3);
        check("bp2_reason", 32'(halt_reason), 32'd2);
      end
    end
    check("bp2_count", adv_count, 32'd18);

    // Simultaneous resume and step in PAUSE (free-run mode): resume wins
    rst = 1'b1;
    tick();
    tick();
    rst      = 1'b0;
    run_mode = 2'b01;
    tick();
    check("both_pause", 32'(state), 32'd1);
    run_mode   = 2'b00;
    step_btn   = 1'b1;
    resume_btn = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 20) begin
        step_btn   = 1'b0;
        resume_btn = 1'b0;
      end
      if (k == 17) check("both_wait", 32'(state), 32'd1);
      if (k == 18) begin
        check("both_resume_wins", 32'(state), 32'd0);
        check("both_go", 32'(go), 32'd1);
      end
      if (k == 19) check("both_stays_run", 32'(state), 32'd0);
    end

    // Breakpoint mode switching acts immediately on go
    pc       = 12'h010;
    run_mode = 2'b10;
    #1;
    check("bpmode_on_go", 32'(go), 32'd0);
    run_mode = 2'b00;
    #1;
    check("bpmode_off_go", 32'(go), 32'd1);
    run_mode = 2'b10;
    tick();
    check("bp3_state", 32'(state), 32'd3);

    // Syscall in the same cycle as resume_p while in BP_HALT
    resume_btn = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 17) syscall_halt = 1'b1;
      if (k == 20) resume_btn = 1'b0;
      if (k == 17) check("bpsys_pre", 32'(state), 32'd3);
      if (k == 18) begin
        check("bpsys_state", 32'(state), 32'd4);
        check("bpsys_reason", 32'(halt_reason), 32'd3);
      end
    end
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("final_rst_state", 32'(state), 32'd0);
    check("final_rst_reason", 32'(halt_reason), 32'd0);
    syscall_halt = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
